// File: rtl/sifh_hist_rmw.sv
// sifh_hist_rmw -- multi-pixel SiFH histogram engine.
// Clears the external histogram SRAM, accumulates TDC hits through a
// one-hit-per-cycle read-modify-write loop with write-to-read forwarding,
// then scans every pixel histogram and reports one peak (bin, count) each.
// Optional build macro SIFH_SAT_CNT_EN adds the 16-bit sat_events counter.
module sifh_hist_rmw #(
   parameter int PIX_W  = 2,
   parameter int BIN_W  = 8,
   parameter int CNT_W  = 10,
   parameter int ADDR_W = PIX_W + BIN_W
) (
   input  logic              clk,
   input  logic              res,
   input  logic              start,
   input  logic              acq_end,
   input  logic              hit_valid,
   output logic              hit_ready,
   input  logic [PIX_W-1:0]  hit_pix,
   input  logic [BIN_W-1:0]  hit_bin,
   output logic              ram_ren,
   output logic [ADDR_W-1:0] ram_raddr,
   input  logic [CNT_W-1:0]  ram_rdata,
   output logic              ram_wen,
   output logic [ADDR_W-1:0] ram_waddr,
   output logic [CNT_W-1:0]  ram_wdata,
   output logic              peak_valid,
   output logic [PIX_W-1:0]  peak_pix,
   output logic [BIN_W-1:0]  peak_bin,
   output logic [CNT_W-1:0]  peak_cnt,
   output logic              busy,
   output logic              done
`ifdef SIFH_SAT_CNT_EN
   ,
   output logic [15:0]       sat_events
`endif
);

   typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, PEAK} stateT;

   stateT             state;
   logic [ADDR_W-1:0] seqAddr;    // CLEAR write address / PEAK read address
   logic              scanRd;     // PEAK reads still being issued
   logic              drainCnt;

   // Accumulate pipeline: stage 2 and the one-cycle forward register
   logic              s2Valid;
   logic [ADDR_W-1:0] s2Addr;
   logic              fwdValid;
   logic [ADDR_W-1:0] fwdAddr;
   logic [CNT_W-1:0]  fwdData;

   // Peak scan compare stage and running maximum of the current pixel
   logic              cmpValid;
   logic [ADDR_W-1:0] cmpAddr;
   logic [CNT_W-1:0]  maxCnt;
   logic [BIN_W-1:0]  maxBin;

   logic              hitAccept;
   logic [CNT_W-1:0]  operand;
   logic              operandSat;
   logic [CNT_W-1:0]  incCnt;
   logic [BIN_W-1:0]  cmpBin;
   logic [PIX_W-1:0]  cmpPix;
   logic [CNT_W-1:0]  candCnt;
   logic [BIN_W-1:0]  candBin;

   assign hit_ready = (state == ACCUM);
   assign busy      = (state != IDLE);
   assign hitAccept = hit_valid & hit_ready;

   // The write one cycle ago has not reached the SRAM read data yet, so a
   // back-to-back hit on the same address takes the forwarded count.
   assign operand    = (fwdValid && (fwdAddr == s2Addr)) ? fwdData : ram_rdata;
   assign operandSat = (operand == '1);
   assign incCnt     = operandSat ? operand : operand + CNT_W'(1);

   assign cmpBin = cmpAddr[BIN_W-1:0];
   assign cmpPix = cmpAddr[ADDR_W-1:BIN_W];

   // SRAM port steering: CLEAR writes zeros, ACCUM reads on handshake and
   // writes from stage 2, PEAK reads sequentially
   always_comb begin
      // NOTE: every signal gets a default first so no latch is inferred.
      ram_ren   = 1'b0;
      ram_raddr = '0;
      ram_wen   = 1'b0;
      ram_waddr = '0;
      ram_wdata = '0;
      case (state)
         CLEAR: begin
            ram_wen   = 1'b1;
            ram_waddr = seqAddr;
         end
         ACCUM: begin
            ram_ren   = hitAccept;
            ram_raddr = {hit_pix, hit_bin};
         end
         PEAK: begin
            ram_ren   = scanRd;
            ram_raddr = seqAddr;
         end
         default: ;
      endcase
      if (s2Valid) begin
         ram_wen   = 1'b1;
         ram_waddr = s2Addr;
         ram_wdata = incCnt;
      end
   end

   // Running maximum: bin 0 restarts it, later bins replace only if strictly greater
   always_comb begin
      candCnt = maxCnt;
      candBin = maxBin;
      if (cmpBin == '0) begin
         candCnt = ram_rdata;
         candBin = '0;
      end else if (ram_rdata > maxCnt) begin
         candCnt = ram_rdata;
         candBin = cmpBin;
      end
   end

   // Control FSM, accumulate pipeline and peak scan with registered outputs
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register sampling the pre-edge values.
      if (res) begin
         // NOTE: the SRAM itself is not reset; CLEAR rewrites it after start.
         state      <= IDLE;
         seqAddr    <= '0;
         scanRd     <= 1'b0;
         drainCnt   <= 1'b0;
         s2Valid    <= 1'b0;
         s2Addr     <= '0;
         fwdValid   <= 1'b0;
         fwdAddr    <= '0;
         fwdData    <= '0;
         cmpValid   <= 1'b0;
         cmpAddr    <= '0;
         maxCnt     <= '0;
         maxBin     <= '0;
         peak_valid <= 1'b0;
         peak_pix   <= '0;
         peak_bin   <= '0;
         peak_cnt   <= '0;
         done       <= 1'b0;
      end else begin
         peak_valid <= 1'b0;
         done       <= 1'b0;
         s2Valid    <= hitAccept;
         s2Addr     <= {hit_pix, hit_bin};
         fwdValid   <= s2Valid;
         fwdAddr    <= s2Addr;
         fwdData    <= incCnt;
         cmpValid   <= (state == PEAK) && scanRd;
         cmpAddr    <= seqAddr;
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= CLEAR;
                  seqAddr <= '0;
               end
            end
            CLEAR: begin
               seqAddr <= seqAddr + ADDR_W'(1);
               if (seqAddr == '1) state <= ACCUM;
            end
            ACCUM: begin
               if (acq_end) begin
                  state    <= DRAIN;
                  drainCnt <= 1'b0;
               end
            end
            DRAIN: begin
               drainCnt <= 1'b1;
               if (drainCnt) begin
                  state   <= PEAK;
                  seqAddr <= '0;
                  scanRd  <= 1'b1;
               end
            end
            PEAK: begin
               if (scanRd) begin
                  seqAddr <= seqAddr + ADDR_W'(1);
                  if (seqAddr == '1) scanRd <= 1'b0;
               end
               if (cmpValid) begin
                  maxCnt <= candCnt;
                  maxBin <= candBin;
                  if (cmpBin == '1) begin
                     peak_valid <= 1'b1;
                     peak_pix   <= cmpPix;
                     peak_bin   <= candBin;
                     peak_cnt   <= candCnt;
                     if (cmpPix == '1) begin
                        done  <= 1'b1;
                        state <= IDLE;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SIFH_SAT_CNT_EN
   // Count hits that landed on an already-saturated bin, saturating at 0xFFFF
   always_ff @(posedge clk) begin
      if (res) begin
         sat_events <= '0;
      end else if ((state == IDLE) && start) begin
         sat_events <= '0;
      end else if (s2Valid && operandSat && (sat_events != 16'hFFFF)) begin
         sat_events <= sat_events + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sifh_hist_rmw.sv
// tb_sifh_hist_rmw -- self-checking bench for sifh_hist_rmw.
// A read-first SRAM model sits on the RAM ports; a count-array reference
// model predicts every SRAM write and every reported peak.
module tb_sifh_hist_rmw;

   localparam int PIX_W  = 2;
   localparam int BIN_W  = 8;
   localparam int CNT_W  = 10;
   localparam int ADDR_W = PIX_W + BIN_W;
   localparam int NPIX   = 1 << PIX_W;
   localparam int NBIN   = 1 << BIN_W;
   localparam int NADDR  = 1 << ADDR_W;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              res;
   logic              start;
   logic              acq_end;
   logic              hit_valid;
   logic              hit_ready;
   logic [PIX_W-1:0]  hit_pix;
   logic [BIN_W-1:0]  hit_bin;
   logic              ram_ren;
   logic [ADDR_W-1:0] ram_raddr;
   logic [CNT_W-1:0]  ram_rdata;
   logic              ram_wen;
   logic [ADDR_W-1:0] ram_waddr;
   logic [CNT_W-1:0]  ram_wdata;
   logic              peak_valid;
   logic [PIX_W-1:0]  peak_pix;
   logic [BIN_W-1:0]  peak_bin;
   logic [CNT_W-1:0]  peak_cnt;
   logic              busy;
   logic              done;
`ifdef SIFH_SAT_CNT_EN
   logic [15:0]       sat_events;
`endif

   sifh_hist_rmw #(.PIX_W(PIX_W), .BIN_W(BIN_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .res(res), .start(start), .acq_end(acq_end),
      .hit_valid(hit_valid), .hit_ready(hit_ready),
      .hit_pix(hit_pix), .hit_bin(hit_bin),
      .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
      .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
      .peak_valid(peak_valid), .peak_pix(peak_pix), .peak_bin(peak_bin),
      .peak_cnt(peak_cnt), .busy(busy), .done(done)
`ifdef SIFH_SAT_CNT_EN
      , .sat_events(sat_events)
`endif
   );

   always #5 clk = ~clk;

   // Dual-port SRAM, read-first on collision, powered up with garbage
   logic [CNT_W-1:0] mem [NADDR];
   initial begin
      ram_rdata = '0;
      for (int i = 0; i < NADDR; i++) mem[i] = CNT_W'($urandom);
      forever begin
         @(posedge clk);
         if (ram_ren) ram_rdata <= mem[ram_raddr];
         if (ram_wen) mem[ram_waddr] <= ram_wdata;
      end
   end

   int passCnt  = 0;
   int totalCnt = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      totalCnt++;
      if (got === exp) passCnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
   endtask

   // Reference model: operating phase plus plain per-bin hit counts
   typedef enum int {M_IDLE, M_CLEAR, M_ACCUM, M_DRAIN, M_PEAK} mPhaseT;
   mPhaseT mPhase = M_IDLE;
   int     mCount;
   int     refCnt [NPIX][NBIN];
   int     satRef;
   bit     pendValid;
   int     pendAddr;
   int     pendData;
   int     peakIdx;
   int     doneCnt;
   int     gotBin [NPIX];
   int     gotCnt [NPIX];

   // Peak of one pixel: first bin holding the largest count
   task automatic refPeak(input int p, output int bin, output int cnt);
      bin = 0;
      cnt = refCnt[p][0];
      for (int b = 1; b < NBIN; b++) begin
         if (refCnt[p][b] > cnt) begin
            cnt = refCnt[p][b];
            bin = b;
         end
      end
   endtask

   // Compare process: outputs are checked mid-cycle, then the model advances
   // with the inputs the DUT samples at the coming edge
   always @(negedge clk) begin
      bit expRen;
      int eb;
      int ec;
      int a;
      check("hit_ready", hit_ready, mPhase == M_ACCUM);
      if (mPhase != M_PEAK) begin
         check("busy", busy, mPhase != M_IDLE);
         check("peak_valid_outside_peak", peak_valid, 1'b0);
         check("done_outside_peak", done, 1'b0);
      end
      case (mPhase)
         M_IDLE: begin
            check("idle_ren", ram_ren, 1'b0);
            check("idle_wen", ram_wen, 1'b0);
         end
         M_CLEAR: begin
            check("clear_ren", ram_ren, 1'b0);
            check("clear_wen", ram_wen, 1'b1);
            check("clear_waddr", ram_waddr, mCount);
            check("clear_wdata", ram_wdata, 0);
         end
         M_ACCUM, M_DRAIN: begin
            expRen = (mPhase == M_ACCUM) && hit_valid;
            check("acc_ren", ram_ren, expRen);
            if (expRen) check("acc_raddr", ram_raddr, hit_pix * NBIN + hit_bin);
            check("acc_wen", ram_wen, pendValid);
            if (pendValid) begin
               check("acc_waddr", ram_waddr, pendAddr);
               check("acc_wdata", ram_wdata, pendData);
            end
         end
         M_PEAK: begin
            check("peak_wen", ram_wen, 1'b0);
            if (peak_valid) begin
               if (peakIdx < NPIX) begin
                  refPeak(peakIdx, eb, ec);
                  check("peak_pix", peak_pix, peakIdx);
                  check("peak_bin", peak_bin, eb);
                  check("peak_cnt", peak_cnt, ec);
                  gotBin[peakIdx] = peak_bin;
                  gotCnt[peakIdx] = peak_cnt;
               end else begin
                  check("peak_extra_pulse", peakIdx, NPIX - 1);
               end
               peakIdx++;
            end
            if (done) doneCnt++;
         end
         default: ;
      endcase

      case (mPhase)
         M_IDLE: begin
            if (start) begin
               mPhase = M_CLEAR;
               mCount = 0;
               satRef = 0;
               peakIdx = 0;
               doneCnt = 0;
               for (int p = 0; p < NPIX; p++) begin
                  gotBin[p] = -1;
                  gotCnt[p] = -1;
                  for (int b = 0; b < NBIN; b++) refCnt[p][b] = 0;
               end
            end
         end
         M_CLEAR: begin
            mCount++;
            if (mCount == NADDR) mPhase = M_ACCUM;
         end
         M_ACCUM: begin
            pendValid = 1'b0;
            if (hit_valid) begin
               if (refCnt[hit_pix][hit_bin] == CMAX) begin
                  if (satRef < 65535) satRef++;
               end else begin
                  refCnt[hit_pix][hit_bin]++;
               end
               a = hit_pix * NBIN + hit_bin;
               pendValid = 1'b1;
               pendAddr = a;
               pendData = refCnt[hit_pix][hit_bin];
            end
            if (acq_end) begin
               mPhase = M_DRAIN;
               mCount = 0;
            end
         end
         M_DRAIN: begin
            pendValid = 1'b0;
            mCount++;
            if (mCount == 2) begin
               mPhase = M_PEAK;
               mCount = 0;
            end
         end
         M_PEAK: begin
            mCount++;
            if (done) begin
               mPhase = M_IDLE;
            end else if (mCount > 3000) begin
               check("peak_scan_timeout", doneCnt, 1);
               mPhase = M_IDLE;
            end
         end
         default: mPhase = M_IDLE;
      endcase
      if (res) begin
         mPhase = M_IDLE;
         pendValid = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int p, input int b);
      hit_valid = 1'b1;
      hit_pix   = PIX_W'(p);
      hit_bin   = BIN_W'(b);
      tick();
   endtask

   task automatic startRun();
      int n;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (mPhase != M_ACCUM && n < 2000) begin
         tick();
         n++;
      end
      check("wait_accum", mPhase, M_ACCUM);
`ifdef SIFH_SAT_CNT_EN
      check("sat_events_cleared", sat_events, 0);
`endif
   endtask

   task automatic endAcq();
      acq_end = 1'b1;
      tick();
      acq_end = 1'b0;
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while (mPhase != M_IDLE && n < 5000) begin
         tick();
         n++;
      end
      check("wait_idle", mPhase, M_IDLE);
      tick();
      check("done_once", doneCnt, 1);
      check("peaks_reported", peakIdx, NPIX);
`ifdef SIFH_SAT_CNT_EN
      check("sat_events", sat_events, satRef);
`endif
   endtask

   task automatic checkPeak(input int p, input int bin, input int cnt);
      check($sformatf("lit_bin_p%0d", p), gotBin[p], bin);
      check($sformatf("lit_cnt_p%0d", p), gotCnt[p], cnt);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      res = 1'b1; start = 1'b0; acq_end = 1'b0;
      hit_valid = 1'b0; hit_pix = '0; hit_bin = '0;
      tick();
      check("rst_busy", busy, 1'b0);
      check("rst_hit_ready", hit_ready, 1'b0);
      check("rst_ren", ram_ren, 1'b0);
      check("rst_wen", ram_wen, 1'b0);
      check("rst_peak_valid", peak_valid, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_peak_fields", {peak_pix, peak_bin, peak_cnt}, 0);
      tick();
      res = 1'b0;
      endAcq();                       // ignored outside ACCUM

      // Reset while hits are streaming
      startRun();
      for (int i = 0; i < 20; i++) send($urandom_range(0, NPIX - 1), $urandom_range(0, 7));
      res = 1'b1;
      tick();
      check("midrst_busy", busy, 1'b0);
      check("midrst_hit_ready", hit_ready, 1'b0);
      check("midrst_wen", ram_wen, 1'b0);
      check("midrst_ren", ram_ren, 1'b0);
      res = 1'b0;
      hit_valid = 1'b0;
      tick();

      // 16 back-to-back hits on one bin
      startRun();
      for (int i = 0; i < 16; i++) send(1, 8'h20);
      hit_valid = 1'b0;
      endAcq();
      waitIdle();
      checkPeak(0, 0, 0);
      checkPeak(1, 8'h20, 16);
      checkPeak(2, 0, 0);
      checkPeak(3, 0, 0);

      // Alternating A,B then A,A,A; a stray start in ACCUM is ignored
      startRun();
      for (int i = 0; i < 4; i++) begin
         start = (i == 1);
         send(0, 8'h11);
         start = 1'b0;
         send(3, 8'h40);
      end
      for (int i = 0; i < 3; i++) send(0, 8'h11);
      hit_valid = 1'b0;
      endAcq();
      waitIdle();
      checkPeak(0, 8'h11, 7);
      checkPeak(1, 0, 0);
      checkPeak(2, 0, 0);
      checkPeak(3, 8'h40, 4);

      // Saturation on the last bin, tie on pix0, hit on the acq_end cycle
      startRun();
      for (int i = 0; i < 1030; i++) send(2, 8'hFF);
      for (int i = 0; i < 3; i++) send(0, 9);
      for (int i = 0; i < 2; i++) send(0, 5);
      acq_end = 1'b1;
      send(0, 5);
      acq_end = 1'b0;
      send(0, 9);                     // hit_ready is low now: not counted
      hit_valid = 1'b0;
      waitIdle();
      checkPeak(0, 5, 3);
      checkPeak(2, 8'hFF, 1023);
`ifdef SIFH_SAT_CNT_EN
      check("lit_sat_events", sat_events, 7);
`endif

      // Random traffic concentrated on a few bins
      startRun();
      for (int i = 0; i < 300; i++) begin
         hit_valid = ($urandom_range(0, 9) < 7);
         hit_pix   = PIX_W'($urandom_range(0, NPIX - 1));
         hit_bin   = ($urandom_range(0, 3) == 0) ? BIN_W'($urandom_range(0, NBIN - 1))
                                                 : BIN_W'($urandom_range(0, 3));
         acq_end   = (i == 299);
         tick();
      end
      acq_end   = 1'b0;
      hit_valid = 1'b1;
      tick();
      hit_valid = 1'b0;
      waitIdle();

      // Second run with no hits: all counts re-cleared
      startRun();
      endAcq();
      waitIdle();
      for (int p = 0; p < NPIX; p++) checkPeak(p, 0, 0);

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
